// File: rtl/core_pkg.sv
// Shared core definitions: AddrMode encodings and memory-arbiter state type.
// Used by the memory arbiter and anything that drives or decodes AddrMode.
// No logic here; constants, types and one AddrMode helper only.
package core_pkg;

    localparam logic [3:0] ADDR_LB   = 4'b0000;
    localparam logic [3:0] ADDR_LH   = 4'b0001;
    localparam logic [3:0] ADDR_LW   = 4'b0010;
    localparam logic [3:0] ADDR_LBU  = 4'b0011;
    localparam logic [3:0] ADDR_LHU  = 4'b0100;
    localparam logic [3:0] ADDR_SB   = 4'b0101;
    localparam logic [3:0] ADDR_SH   = 4'b0110;
    localparam logic [3:0] ADDR_SW   = 4'b0111;
    localparam logic [3:0] ADDR_NONE = 4'b1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // A data request carrying ADDR_NONE is a bubble, not a memory access.
    function automatic logic is_mem_access(input logic [3:0] mode);
        return mode != ADDR_NONE;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter: counts cycles a requester is left waiting.
// Latency: sat reflects the registered count, one cycle after the last inc.
// Backpressure: none; clr has priority over inc.
module starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Latency: grant registered, mem_req next cycle; valid on the mem_ack cycle.
// Backpressure: requester holds req until its valid; stall_* freeze the pipe.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_addrmode,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_addrmode,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  stall_if,
    output logic                  stall_mem
);

    arb_state_t state, state_nxt;
    logic       arb_pt;
    logic       if_cand, d_cand;
    logic       grant_i, grant_d;
    logic       starve_sat, starve_inc;

    // The requester being acked still has req high this cycle, so it is masked out.
    assign arb_pt  = (state == IDLE) || mem_ack;
    assign if_cand = if_req && (state != BUSY_I);
    assign d_cand  = d_req && is_mem_access(d_addrmode) && (state != BUSY_D);

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        if (arb_pt) begin
            if (if_cand && starve_sat) begin
                grant_i = 1'b1;
            end else if (d_cand) begin
                grant_d = 1'b1;
            end else if (if_cand) begin
                grant_i = 1'b1;
            end
            if (grant_i) begin
                state_nxt = BUSY_I;
            end else if (grant_d) begin
                state_nxt = BUSY_D;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Winner's request is frozen here so the memory sees a stable transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_addrmode <= ADDR_NONE;
        end else if (grant_i) begin
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            mem_addrmode <= ADDR_LW;
        end else if (grant_d) begin
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
            mem_addrmode <= d_addrmode;
        end
    end

    assign starve_inc = if_req && (state != BUSY_I);

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc),
        .clr   (grant_i),
        .sat   (starve_sat)
    );

    assign mem_req   = (state != IDLE);
    assign if_valid  = mem_ack && (state == BUSY_I);
    assign d_valid   = mem_ack && (state == BUSY_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign stall_if  = if_req && !if_valid;
    assign stall_mem = d_req && !d_valid;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port unified memory between the instruction-fetch (IF) port and the data (load/store) port of the core. Data accesses are encoded with the 4-bit AddrMode produced by the control unit. The block holds the winning request on the memory port until the memory acknowledges it, and routes the response back to the winning requester. It raises per-port stall signals so the pipeline freezes while a port waits. It sits between the fetch/memory stages and the memory model.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive cycles IF may wait before it overrides data priority (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched word
- if_valid  out  1  one-cycle fetch response
- d_req  in  1  data request; held until d_valid
- d_addr  in  ADDR_WIDTH  data address (ALU result)
- d_wdata  in  DATA_WIDTH  store data
- d_addrmode  in  4  AddrMode: 0000–0100 loads, 0101–0111 stores, 1000 none
- d_rdata  out  DATA_WIDTH  load data
- d_valid  out  1  one-cycle data response
- mem_req  out  1  memory request
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_addrmode  out  4  mode to memory; fetch uses 0010 (LW)
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_ack  in  1  memory transaction complete; rdata valid this cycle
- stall_if  out  1  if_req && !if_valid
- stall_mem  out  1  d_req && !d_valid

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- Effective data request is d_req && d_addrmode != 1000. AddrMode 1000 with d_req is treated as no request.
- Arbitration runs in IDLE and on the mem_ack cycle in BUSY_*:
  - Data wins by default.
  - IF wins if starve_cnt == STARVE_LIMIT.
  - On the ack cycle, the requester just served is excluded from arbitration (its req is still high that cycle).
- Next state:
  - IF winner → BUSY_I.
  - Data winner → BUSY_D.
  - No winner → IDLE.
  - BUSY_* without mem_ack stays put.
- The grant is latched: mem_addr, mem_wdata and mem_addrmode are registered copies of the winner's request, captured on the grant. They are stable for the whole transaction. Inputs are not re-sampled.
- mem_req = (state != IDLE), from a registered state.
- Responses:
  - if_valid = mem_ack && state==BUSY_I.
  - d_valid = mem_ack && state==BUSY_D.
  - if_rdata and d_rdata pass mem_rdata through combinationally.
  - Stores pulse d_valid; d_rdata is don't-care.
- starve_cnt:
  - Increments each cycle that if_req is high and state != BUSY_I.
  - Saturates at STARVE_LIMIT.
  - Clears when IF is granted.
- A requester dropping its request mid-transaction does not abort the transaction. The valid still pulses.
- mem_ack in IDLE is ignored; no valid is raised.

## Timing
- Reset values:
  - state IDLE, mem_req 0, mem_addr/mem_wdata 0, mem_addrmode 1000.
  - starve_cnt 0, if_valid/d_valid 0.
  - if_rdata/d_rdata follow mem_rdata.
- Minimum latency: request seen in cycle N → mem_req in N+1 → earliest valid in N+1 (if mem_ack is combinational), otherwise on the cycle mem_ack arrives.
- Back-to-back transfers: on the ack cycle the next grant is taken, mem_req stays high, and a new address appears in cycle ack+1. There is no bubble. The memory must treat each ack as the end of its transaction.
- Simultaneous requests in IDLE: data first, IF granted on the data ack cycle.
- Reset asserted mid-transaction:
  - Immediately returns to IDLE and drops mem_req.
  - Any later stray mem_ack is ignored.

## Structure
- Shared package core_pkg:
  - AddrMode constants: ADDR_LB … ADDR_SW, ADDR_NONE = 4'b1000, ADDR_LW = 4'b0010.
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}.
- One sub-module: starve_counter, a saturating counter parameterised by STARVE_LIMIT with inc/clr/sat ports.

## Test plan
- IF-only fetch to 0x0000_0010, memory acks after 2 cycles with 0x00A0_0093 → if_valid pulses once with that word; stall_if is high until that pulse.
- if_req and d_req (LW, addrmode 0010, 0x100) rise together → data served first, IF granted on the data ack cycle, mem_addr switches to the fetch address the next cycle, no IDLE gap.
- Store SW (0111) of 0xDEADBEEF to 0x200 → mem_addrmode 0111, mem_wdata 0xDEADBEEF held until ack; d_valid pulses once.
- Data requests continuously, IF waiting, STARVE_LIMIT=4 → IF granted at the first arbitration point after starve_cnt reaches 4; counter clears on the grant.
- d_req with addrmode 1000 → no mem_req; stall_mem stays high and no d_valid is ever produced (protocol check).
- rst_n pulsed low during BUSY_D → mem_req 0 immediately; a subsequent mem_ack produces no valid; normal operation after release.
